// File: rtl/volt_mon_pkg.sv
// volt_mon_pkg: shared types, default thresholds and helpers for the voltage level monitor
package volt_mon_pkg;
  typedef logic [2:0] level_t;
  typedef enum logic [1:0] {IDLE, ARMING, TRIPPED, RELEASING} state_t;
  localparam logic [15:0] TH1_DEF = 16'd1000;
  localparam logic [15:0] TH2_DEF = 16'd2000;
  localparam logic [15:0] TH3_DEF = 16'd3000;
  localparam logic [15:0] TH4_DEF = 16'd4000;
  localparam logic [15:0] HYST_DEF = 16'd50;
  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a - b : 16'd0;
  endfunction
  function automatic level_t therm_level(input logic [3:0] b);
    return level_t'(b[0]) + level_t'(b[1]) + level_t'(b[2]) + level_t'(b[3]);
  endfunction
endpackage

// File: rtl/volt_level_monitor_if.sv
// volt_level_monitor_if: ADC sample stream in, averaged voltage stream out
interface volt_level_monitor_if;
  logic        sample_vld;
  logic [15:0] sample;
  logic [15:0] avg_volt;
  logic        avg_vld;
  modport master(output sample_vld, sample, input avg_volt, avg_vld);
  modport slave(input sample_vld, sample, output avg_volt, avg_vld);
endinterface

// File: rtl/volt_boxcar_avg.sv
// volt_boxcar_avg: averages 2**AVG_LOG2 consecutive samples, one-cycle valid per result
module volt_boxcar_avg #(
  parameter int AVG_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_vld,
  input  logic [15:0] sample,
  output logic [15:0] avg_volt,
  output logic        avg_vld
);
  logic [15+AVG_LOG2:0] sum, sum_nxt;
  logic [AVG_LOG2-1:0]  cnt;
  assign sum_nxt = sum + {{AVG_LOG2{1'b0}}, sample};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum      <= '0;
      cnt      <= '0;
      avg_volt <= '0;
      avg_vld  <= 1'b0;
    end else begin
      avg_vld <= sample_vld && &cnt;
      if (sample_vld) begin
        cnt <= cnt + AVG_LOG2'(1);
        sum <= &cnt ? '0 : sum_nxt;
        if (&cnt) avg_volt <= 16'(sum_nxt >> AVG_LOG2);
      end
    end
endmodule

// File: rtl/volt_level_monitor.sv
// volt_level_monitor: averaged voltage classified into 5 hysteretic levels, LED bar and debounced over-voltage relay
module volt_level_monitor
  import volt_mon_pkg::*;
#(
  parameter int          AVG_LOG2    = 3,
  parameter logic [15:0] TH1         = TH1_DEF,
  parameter logic [15:0] TH2         = TH2_DEF,
  parameter logic [15:0] TH3         = TH3_DEF,
  parameter logic [15:0] TH4         = TH4_DEF,
  parameter logic [15:0] HYST        = HYST_DEF,
  parameter int          TRIP_CNT    = 4,
  parameter int          K_HOLD_CLKS = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  volt_level_monitor_if.slave  bus,
  output level_t               level,
  output logic                 LED1,
  output logic                 LED2,
  output logic                 LED3,
  output logic                 LED4,
  output logic                 LED5,
  output logic                 K_1
);
  localparam int CW = (TRIP_CNT < 2) ? 1 : $clog2(TRIP_CNT + 1);
  localparam int HW = $clog2(K_HOLD_CLKS + 1);
  localparam logic [15:0] TH_A [4] = '{TH1, TH2, TH3, TH4};
  logic [3:0]    bits, bits_nxt;
  level_t        lvl_nxt;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [HW-1:0] hold;
  logic          ev, hi, hold_done, entering;
  volt_boxcar_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_vld (bus.sample_vld),
    .sample     (bus.sample),
    .avg_volt   (bus.avg_volt),
    .avg_vld    (bus.avg_vld)
  );
  // each bit sets at its threshold and only drops below threshold minus hysteresis
  for (genvar i = 0; i < 4; i++) begin : g_hyst
    assign bits_nxt[i] = bus.avg_volt >= TH_A[i] ||
                         (bus.avg_volt >= sat_sub(TH_A[i], HYST) && bits[i]);
  end
  assign ev        = bus.avg_vld;
  assign lvl_nxt   = therm_level(bits_nxt);
  assign hi        = lvl_nxt == 3'd4;
  assign level     = therm_level(bits);
  assign hold_done = hold >= HW'(K_HOLD_CLKS);
  assign entering  = state_nxt == TRIPPED && (state == IDLE || state == ARMING);
  assign LED1 = level == 3'd0;
  assign LED2 = level == 3'd1;
  assign LED3 = level == 3'd2;
  assign LED4 = level == 3'd3;
  assign LED5 = level == 3'd4;
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (ev && hi) begin
        state_nxt = (TRIP_CNT == 1) ? TRIPPED : ARMING;
        cnt_nxt   = (TRIP_CNT == 1) ? '0 : CW'(1);
      end
      ARMING: if (ev) begin
        state_nxt = !hi ? IDLE : (cnt + CW'(1) >= CW'(TRIP_CNT)) ? TRIPPED : ARMING;
        cnt_nxt   = (state_nxt == ARMING) ? cnt + CW'(1) : '0;
      end
      TRIPPED: if (ev && !hi) begin
        state_nxt = RELEASING;
        cnt_nxt   = CW'(1);
      end
      RELEASING: if (ev && hi) begin
        state_nxt = TRIPPED;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt   = (ev && cnt < CW'(TRIP_CNT)) ? cnt + CW'(1) : cnt;
        state_nxt = (cnt_nxt >= CW'(TRIP_CNT) && hold_done) ? IDLE : RELEASING;
        cnt_nxt   = (state_nxt == IDLE) ? '0 : cnt_nxt;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bits  <= '0;
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      K_1   <= 1'b0;
    end else begin
      if (ev) bits <= bits_nxt;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      K_1   <= state_nxt == TRIPPED || state_nxt == RELEASING;
      hold  <= entering ? '0 :
               ((state == TRIPPED || state == RELEASING) && !hold_done) ? hold + HW'(1) : hold;
    end
endmodule

// File: tb/tb_volt_level_monitor.sv
// tb_volt_level_monitor: scoreboard bench for averaging, level hysteresis and relay timing
module tb_volt_level_monitor;
  typedef struct {
    logic [15:0] avg;
    int          lvl;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] level;
  logic       LED1, LED2, LED3, LED4, LED5, K_1;
  volt_level_monitor_if vif();
  volt_level_monitor #(.K_HOLD_CLKS(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif),
    .level (level),
    .LED1  (LED1),
    .LED2  (LED2),
    .LED3  (LED3),
    .LED4  (LED4),
    .LED5  (LED5),
    .K_1   (K_1)
  );
  always #5 clk = ~clk;
  int   checks = 0, errors = 0;
  exp_t q[$];
  int   m_sum = 0, m_n = 0;
  logic [3:0] m_bits = '0;
  int   th[4] = '{1000, 2000, 3000, 4000};
  int   exp_lvl = 0, cyc = 0, rise = 0, fall = 0;
  bit   lvl_pend = 0;
  logic k_prev = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic strobe(input logic [15:0] v);
    int a;
    vif.sample_vld = 1'b1;
    vif.sample     = v;
    m_sum += int'(v);
    m_n++;
    if (m_n == 8) begin
      a = m_sum / 8;
      for (int i = 0; i < 4; i++)
        if (a >= th[i]) m_bits[i] = 1'b1;
        else if (a < th[i] - 50) m_bits[i] = 1'b0;
      q.push_back('{16'(a), $countones(m_bits)});
      m_sum = 0;
      m_n   = 0;
    end
    @(posedge clk);
    #1 vif.sample_vld = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_avg(input logic [15:0] v, input int gap);
    repeat (8) strobe(v);
    idle(gap);
  endtask
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (lvl_pend) begin
      chk("level", 32'(level), 32'(exp_lvl));
      chk("leds", 32'({LED5, LED4, LED3, LED2, LED1}), 32'(1 << exp_lvl));
      lvl_pend = 0;
    end
    if (vif.avg_vld) begin
      if (q.size() == 0) chk("spurious_avg", 32'(vif.avg_volt), 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        chk("avg", 32'(vif.avg_volt), 32'(e.avg));
        exp_lvl  = e.lvl;
        lvl_pend = 1;
      end
    end
    if (K_1 && !k_prev) rise = cyc;
    if (!K_1 && k_prev) fall = cyc;
    k_prev = K_1;
  end
  initial begin
    rst_n          = 1'b0;
    vif.sample_vld = 1'b0;
    vif.sample     = '0;
    idle(2);
    chk("rst_avg", 32'(vif.avg_volt), 0);
    chk("rst_vld", 32'(vif.avg_vld), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_leds", 32'({LED5, LED4, LED3, LED2, LED1}), 1);
    chk("rst_k1", 32'(K_1), 0);
    rst_n = 1'b1;
    idle(2);
    repeat (7) strobe(16'd1500);
    chk("vld_early", 32'(vif.avg_vld), 0);
    strobe(16'd1500);
    chk("vld_latency", 32'(vif.avg_vld), 1);
    idle(3);
    repeat (7) strobe(16'd0);
    strobe(16'd7);
    idle(3);
    send_avg(16'hFFFF, 3);
    send_avg(16'd2010, 3);
    send_avg(16'd1960, 3);
    send_avg(16'd1949, 3);
    send_avg(16'd4100, 3);
    send_avg(16'd0, 3);
    repeat (3) send_avg(16'd4100, 3);
    send_avg(16'd3000, 3);
    chk("k1_no_trip", 32'(K_1), 0);
    repeat (3) send_avg(16'd4100, 3);
    chk("k1_armed", 32'(K_1), 0);
    send_avg(16'd4100, 3);
    chk("k1_trip", 32'(K_1), 1);
    for (int i = 0; i < 15 && K_1; i++) begin
      if (i == 5) chk("k1_hold", 32'(K_1), 1);
      send_avg(16'd3000, 2);
    end
    chk("k1_release", 32'(K_1), 0);
    chk("hold_dur", 32'(fall - rise), 101);
    repeat (4) send_avg(16'd4100, 2);
    chk("k1_trip2", 32'(K_1), 1);
    idle(120);
    repeat (3) send_avg(16'd3000, 2);
    chk("k1_rel3", 32'(K_1), 1);
    send_avg(16'd4100, 2);
    chk("k1_retrip", 32'(K_1), 1);
    repeat (3) send_avg(16'd3000, 2);
    chk("k1_restart", 32'(K_1), 1);
    send_avg(16'd3000, 2);
    chk("k1_rel_final", 32'(K_1), 0);
    repeat (4) send_avg(16'd4100, 2);
    chk("k1_trip3", 32'(K_1), 1);
    repeat (5) strobe(16'd100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_avg", 32'(vif.avg_volt), 0);
    chk("mid_rst_vld", 32'(vif.avg_vld), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_leds", 32'({LED5, LED4, LED3, LED2, LED1}), 1);
    chk("mid_rst_k1", 32'(K_1), 0);
    q.delete();
    lvl_pend = 0;
    m_sum    = 0;
    m_n      = 0;
    m_bits   = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    repeat (8) strobe(16'd1234);
    idle(3);
    chk("post_rst_k1", 32'(K_1), 0);
    idle(5);
    chk("drain", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
